// File: rtl/snap_pkg.sv
// Definitions shared by the snapshot capture controller and the software driver:
// FSM state encoding and the status-word bit positions.
package snap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } snap_state_e;

    localparam int ST_DONE = 31;
    localparam int ST_BUSY = 30;
    localparam int ST_WAIT = 29;

    // Words-written field sits in the low bits; flags overlay the top three bits.
    function automatic logic [31:0] pack_status(snap_state_e st, logic [31:0] words);
        logic [31:0] s;
        s          = words;
        s[ST_DONE] = (st == DONE);
        s[ST_BUSY] = (st == ARMED) || (st == CAPTURE);
        s[ST_WAIT] = (st == ARMED);
        return s;
    endfunction

endpackage

// File: rtl/snap_edge_det.sv
// Rising-edge detector: one-cycle pulse when d goes 0->1; history flop cleared by reset
// so a level already high when reset releases still counts as an edge.
module snap_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/adc_snap_capture_ctrl.sv
// Snapshot capture controller: arm on ctrl[0] edge, wait for trigger, then write
// 2**ADDR_W valid ADC words into the snapshot BRAM and report progress in status.
module adc_snap_capture_ctrl
    import snap_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl,
    input  logic              trig,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status
);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(2 ** ADDR_W - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    snap_state_e     state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            arm_rise;
    logic            trig_hit;
    logic            accept;
    logic            unused_ctrl;

    assign unused_ctrl = ^ctrl[31:2];

    snap_edge_det u_arm_edge (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .d     (ctrl[0]),
        .rise  (arm_rise)
    );

    assign trig_hit = (ctrl[1] ? trig : 1'b1) & din_valid;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm_rise) begin
                    state_d = ARMED;
                    count_d = '0;
                end
            end
            ARMED: begin
                // A fresh arm edge restarts the wait rather than racing the trigger.
                if (arm_rise) begin
                    count_d = '0;
                end else if (trig_hit) begin
                    accept  = 1'b1;
                    count_d = CNT_ONE;
                    state_d = (CNT_FULL == CNT_ONE) ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                if (din_valid) begin
                    accept = 1'b1;
                    if (count_q != CNT_FULL) count_d = count_q + CNT_ONE;
                    if (count_q == CNT_LAST) state_d = DONE;
                end
            end
            DONE: begin
                if (arm_rise) begin
                    state_d = ARMED;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status is registered from next-state values so it lines up with the write it reflects.
    // NOTE: the write data register is reset too, since all outputs must read 0 after reset.
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_data <= '0;
            status    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bram_we <= accept;
            if (accept) begin
                bram_addr <= count_q[ADDR_W-1:0];
                bram_data <= din;
            end
            status <= pack_status(state_d, 32'(count_d));
        end
    end

endmodule

// File: tb/tb_adc_snap_capture_ctrl.sv
// Self-checking bench for adc_snap_capture_ctrl: reference model predicts each cycle's
// outputs into a queue; a monitor pops and compares after every rising edge.
module tb_adc_snap_capture_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              user_rst_n;
    logic [31:0]       ctrl;
    logic              trig;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic [31:0]       status;

    adc_snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk   (clk),
        .user_rst_n (user_rst_n),
        .ctrl       (ctrl),
        .trig       (trig),
        .din        (din),
        .din_valid  (din_valid),
        .bram_addr  (bram_addr),
        .bram_data  (bram_data),
        .bram_we    (bram_we),
        .status     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [31:0]       status;
        logic              all;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            if (fails <= 50) $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, req, $time);
        end
    endtask

    // Reference model: a capture session described as flags plus a word tally.
    bit m_prev, m_waiting, m_running, m_done;
    int m_words;

    task automatic model_cycle();
        exp_t e;
        bit   rise;
        e = '{we: 1'b0, addr: '0, data: '0, status: '0, all: 1'b0};
        if (!user_rst_n) begin
            m_prev = 0; m_waiting = 0; m_running = 0; m_done = 0; m_words = 0;
            e.all = 1'b1;
        end else begin
            rise   = ctrl[0] && !m_prev;
            m_prev = ctrl[0];
            if (m_waiting) begin
                if (rise) m_words = 0;
                else if (din_valid && (!ctrl[1] || trig)) begin
                    e.we = 1; e.addr = '0; e.data = din;
                    m_words = 1; m_waiting = 0; m_running = 1;
                end
            end else if (m_running) begin
                if (din_valid) begin
                    e.we = 1; e.addr = ADDR_W'(m_words % DEPTH); e.data = din;
                    m_words++;
                    if (m_words == DEPTH) begin m_running = 0; m_done = 1; end
                end
            end else if (rise) begin
                m_waiting = 1; m_done = 0; m_words = 0;
            end
        end
        e.status = 32'(m_words) + (m_done ? 32'h8000_0000 : 0)
                 + ((m_waiting || m_running) ? 32'h4000_0000 : 0)
                 + (m_waiting ? 32'h2000_0000 : 0);
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        model_cycle();
        @(negedge clk);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bram_we", 64'(bram_we), 64'(e.we));
            check("status", 64'(status), 64'(e.status));
            if (e.we || e.all) begin
                check("bram_addr", 64'(bram_addr), 64'(e.addr));
                check("bram_data", bram_data, e.data);
            end
        end
    end

    task automatic run_to_done(input string name, input int mode, input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            din = {$urandom, $urandom};
            case (mode)
                0: din_valid = 1'b1;
                1: din_valid = ~din_valid;
                default: din_valid = 1'($urandom);
            endcase
            cyc();
            n++;
        end
        check({name, "_finished"}, 64'(m_done), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        user_rst_n = 0; ctrl = '0; trig = 0; din = '0; din_valid = 0;
        cyc(); cyc();
        check("reset_status", 64'(status), 64'(0));
        check("reset_we", 64'(bram_we), 64'(0));
        user_rst_n = 1;
        cyc();

        // 1: immediate trigger, incrementing data, valid every cycle
        ctrl = 32'h1; din_valid = 1;
        for (int n = 0; n < DEPTH + 10 && !m_done; n++) begin
            din = 64'(n) + 64'h1000;
            cyc();
        end
        check("t1_final_status", 64'(status), 64'h8000_0800);
        check("t1_final_we", 64'(bram_we), 64'(1));
        check("t1_final_addr", 64'(bram_addr), 64'(DEPTH - 1));
        cyc();
        check("t1_we_after", 64'(bram_we), 64'(0));

        // 2: external trigger held low, then pulsed; 3: alternating valid
        ctrl = 32'h2; cyc();
        ctrl = 32'h3; trig = 0;
        for (int n = 0; n < 100; n++) begin din = {$urandom, $urandom}; cyc(); end
        check("t2_waiting_status", 64'(status), 64'h6000_0000);
        trig = 1; din = 64'hABCD; din_valid = 1; cyc();
        trig = 0;
        check("t2_trig_we", 64'(bram_we), 64'(1));
        check("t2_trig_addr", 64'(bram_addr), 64'(0));
        check("t2_trig_data", bram_data, 64'hABCD);
        run_to_done("t3", 1, 2 * DEPTH + 10);

        // 4: held arm does not re-arm; a fresh edge does
        for (int n = 0; n < 50; n++) cyc();
        check("t4_hold_status", 64'(status), 64'h8000_0800);
        ctrl = 32'h0; cyc();
        ctrl = 32'h1; din_valid = 0; cyc();
        check("t4_rearm_status", 64'(status), 64'h6000_0000);

        // 5: reset mid-capture at 500 words, then a clean restart
        for (int n = 0; n < 4 * DEPTH && m_words < 500; n++) begin
            din = {$urandom, $urandom}; din_valid = 1'($urandom); cyc();
        end
        user_rst_n = 0; ctrl = '0; din_valid = 1; cyc();
        user_rst_n = 1;
        check("t5_reset_status", 64'(status), 64'(0));
        check("t5_reset_we", 64'(bram_we), 64'(0));
        for (int n = 0; n < 5; n++) cyc();
        ctrl = 32'h1; cyc();
        run_to_done("t5", 2, 4 * DEPTH);

        // 6: arm edge coincident with trigger is ignored; arm edge while waiting restarts wait
        ctrl = 32'h0; cyc();
        ctrl = 32'h3; trig = 1; din_valid = 1; cyc();
        trig = 0;
        for (int n = 0; n < 20; n++) begin din = {$urandom, $urandom}; cyc(); end
        check("t6_still_armed", 64'(status), 64'h6000_0000);
        ctrl = 32'h2; cyc();
        ctrl = 32'h3; trig = 1; cyc();
        trig = 0; cyc();
        check("t6_rearm_nowrite", 64'(status), 64'h6000_0000);
        trig = 1; cyc();
        trig = 0;
        run_to_done("t6", 2, 4 * DEPTH);

        cyc(); cyc();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
